// File: rtl/matrix_term_sequencer_pkg.sv
// Shared sizing, state encoding and address helpers for the matrix term sequencer.
package matrix_pkg;

    localparam int ELEM_WIDTH = 8;
    localparam int M_SIZE     = 4;
    localparam int DATA_WIDTH = 2 * ELEM_WIDTH;
    localparam int IDX_WIDTH  = $clog2(M_SIZE);
    localparam int HALF_COUNT = M_SIZE * M_SIZE;
    localparam int LOAD_COUNT = 2 * M_SIZE * M_SIZE;
    localparam int ADDR_WIDTH = $clog2(LOAD_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    // Slot of A[i][k]; A is stored row-major in the lower half.
    function automatic logic [ADDR_WIDTH-1:0] a_addr(input logic [IDX_WIDTH-1:0] i,
                                                     input logic [IDX_WIDTH-1:0] k);
        return ADDR_WIDTH'(int'(i) * M_SIZE + int'(k));
    endfunction

    // Slot of B[k][j]; B is stored row-major in the upper half.
    function automatic logic [ADDR_WIDTH-1:0] b_addr(input logic [IDX_WIDTH-1:0] k,
                                                     input logic [IDX_WIDTH-1:0] j);
        return ADDR_WIDTH'(HALF_COUNT + int'(k) * M_SIZE + int'(j));
    endfunction

endpackage

// File: rtl/matrix_term_sequencer_if.sv
// Operand byte stream in, accumulate-unit term stream and job status out.
interface matrix_term_sequencer_if;
    import matrix_pkg::*;

    logic                  start;
    logic [ELEM_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  acc_enable;
    logic                  acc_clear;
    logic                  term_last;
    logic [IDX_WIDTH-1:0]  row_idx;
    logic [IDX_WIDTH-1:0]  col_idx;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, result, acc_enable, acc_clear, term_last,
               row_idx, col_idx, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, result, acc_enable, acc_clear, term_last,
               row_idx, col_idx, busy, done
    );

endinterface

// File: rtl/matrix_term_sequencer_operand_buffer.sv
// Register file holding A (slots 0-15) and B (slots 16-31); one write, two async reads.
module matrix_operand_buffer
    import matrix_pkg::*;
(
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ELEM_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [ELEM_WIDTH-1:0] rdata_a,
    output logic [ELEM_WIDTH-1:0] rdata_b
);

    // Storage is deliberately not reset: every job rewrites all slots before reading.
    logic [ELEM_WIDTH-1:0] mem [LOAD_COUNT];

    // Capture one operand byte per accepted handshake.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/matrix_term_sequencer.sv
// Loads A and B, then streams clear + four partial products per element of C = A*B.
module matrix_term_sequencer
    import matrix_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    matrix_term_sequencer_if.slave  bus
);

    localparam logic [IDX_WIDTH-1:0]  IDX_MAX  = IDX_WIDTH'(M_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LOAD_MAX = ADDR_WIDTH'(LOAD_COUNT - 1);

    seq_state_t            state, state_n;
    logic [ADDR_WIDTH-1:0] load_cnt, load_cnt_n;
    logic [IDX_WIDTH-1:0]  i_q, j_q, k_q, i_n, j_n, k_n;
    logic                  phase_q, phase_n;   // 0: clear step, 1: term step k

    logic                  in_ready_q;
    logic                  hs;
    logic                  step_clear_n, step_term_n;

    logic [ELEM_WIDTH-1:0] op_a, op_b;
    logic [DATA_WIDTH-1:0] product;

    logic [DATA_WIDTH-1:0] result_q;
    logic                  acc_enable_q, acc_clear_q, term_last_q, busy_q, done_q;
    logic [IDX_WIDTH-1:0]  row_q, col_q;

    // in_ready_q mirrors state==LOAD, so this is the accepted-byte strobe.
    assign hs = in_ready_q & bus.in_valid;

    matrix_operand_buffer u_buf (
        .clock   (clock),
        .we      (hs),
        .waddr   (load_cnt),
        .wdata   (bus.in_data),
        .raddr_a (a_addr(i_n, k_n)),
        .raddr_b (b_addr(k_n, j_n)),
        .rdata_a (op_a),
        .rdata_b (op_b)
    );

    assign product = DATA_WIDTH'(op_a) * DATA_WIDTH'(op_b);

    // State and sequencing counters; counters name the step shown on the outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            load_cnt <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            phase_q  <= 1'b0;
        end else begin
            state    <= state_n;
            load_cnt <= load_cnt_n;
            i_q      <= i_n;
            j_q      <= j_n;
            k_q      <= k_n;
            phase_q  <= phase_n;
        end
    end

    // Next state and next step: clear, then k=0..3, walking (i,j) row-major.
    always_comb begin
        state_n    = state;
        load_cnt_n = load_cnt;
        i_n        = i_q;
        j_n        = j_q;
        k_n        = k_q;
        phase_n    = phase_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n    = LOAD;
                    load_cnt_n = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    load_cnt_n = load_cnt + ADDR_WIDTH'(1);
                    if (load_cnt == LOAD_MAX) begin
                        state_n = COMPUTE;
                        i_n     = '0;
                        j_n     = '0;
                        k_n     = '0;
                        phase_n = 1'b0;
                    end
                end
            end
            COMPUTE: begin
                if (!phase_q) begin
                    phase_n = 1'b1;
                    k_n     = '0;
                end else if (k_q != IDX_MAX) begin
                    k_n = k_q + IDX_WIDTH'(1);
                end else begin
                    phase_n = 1'b0;
                    k_n     = '0;
                    if (j_q != IDX_MAX) begin
                        j_n = j_q + IDX_WIDTH'(1);
                    end else begin
                        j_n = '0;
                        if (i_q != IDX_MAX) begin
                            i_n = i_q + IDX_WIDTH'(1);
                        end else begin
                            i_n     = '0;
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign step_clear_n = (state_n == COMPUTE) && !phase_n;
    assign step_term_n  = (state_n == COMPUTE) &&  phase_n;

    // Register every output from the decoded next step so they align with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q     <= '0;
            acc_enable_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            term_last_q  <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            result_q     <= step_term_n ? product : '0;
            acc_enable_q <= step_term_n;
            acc_clear_q  <= step_clear_n;
            term_last_q  <= step_term_n && (k_n == IDX_MAX);
            row_q        <= (state_n == COMPUTE) ? i_n : '0;
            col_q        <= (state_n == COMPUTE) ? j_n : '0;
            busy_q       <= (state_n != IDLE);
            done_q       <= (state_n == DONE);
            in_ready_q   <= (state_n == LOAD);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.result     = result_q;
    assign bus.acc_enable = acc_enable_q;
    assign bus.acc_clear  = acc_clear_q;
    assign bus.term_last  = term_last_q;
    assign bus.row_idx    = row_q;
    assign bus.col_idx    = col_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_matrix_term_sequencer.sv
// Scoreboard bench: jobs push the expected term stream; a negedge monitor checks it.
module tb_matrix_term_sequencer;
    import matrix_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    matrix_term_sequencer_if bus();

    matrix_term_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit clr;
        int i;
        int j;
        int val;
        bit last;
    } exp_t;

    exp_t exq[$];
    int   sumq[$];
    exp_t mon_e;
    int   mon_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int job_base = 0;
    int n_clr, n_en, n_last, n_done, done_at, first_clr_at, acc_sum;
    int a_m[16];
    int b_m[16];

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.result, bus.acc_enable, bus.acc_clear, bus.term_last,
                    bus.row_idx, bus.col_idx, bus.busy, bus.done, bus.in_ready});
    endfunction

    // Monitor: every COMPUTE step is popped and compared; everything else must be quiet.
    always @(negedge clock) begin
        if (!reset) begin
            chk("clr_en_exclusive", 64'(bus.acc_clear & bus.acc_enable), 64'd0);
            if (bus.acc_clear || bus.acc_enable) begin
                if (bus.acc_clear) begin
                    n_clr++;
                    acc_sum = 0;
                    if (first_clr_at == 0) first_clr_at = cyc_cnt - job_base + 1;
                end
                if (bus.acc_enable) begin
                    n_en++;
                    acc_sum += int'(bus.result);
                end
                if (exq.size() == 0) begin
                    chk("unexpected_step", 64'd1, 64'd0);
                end else begin
                    mon_e = exq.pop_front();
                    chk("step", 64'({bus.acc_clear, bus.acc_enable, bus.row_idx, bus.col_idx,
                                     bus.result, bus.term_last}),
                        64'({mon_e.clr, ~mon_e.clr, 2'(mon_e.i), 2'(mon_e.j),
                             16'(mon_e.val), mon_e.last}));
                end
                if (bus.term_last) begin
                    n_last++;
                    if (sumq.size() == 0) begin
                        chk("unexpected_sum", 64'd1, 64'd0);
                    end else begin
                        mon_s = sumq.pop_front();
                        chk("elem_sum", 64'(acc_sum), 64'(mon_s));
                    end
                end
            end else begin
                chk("idle_quiet", 64'({bus.result, bus.term_last, bus.row_idx, bus.col_idx}), 64'd0);
            end
            if (bus.done) begin
                n_done++;
                done_at = cyc_cnt - job_base + 1;
            end
        end
    end

    // Operand patterns: 0 identity/1..16, 1 all 255, 2 random.
    task automatic set_mats(input int mode);
        for (int s = 0; s < 16; s++) begin
            case (mode)
                0: begin a_m[s] = (s / 4 == s % 4) ? 1 : 0; b_m[s] = s + 1; end
                1: begin a_m[s] = 255; b_m[s] = 255; end
                default: begin a_m[s] = int'($urandom_range(0, 255)); b_m[s] = int'($urandom_range(0, 255)); end
            endcase
        end
    endtask

    // vmode: 0 valid held, 1 valid toggles 1/0, 2 random valid.
    task automatic run_job(input int vmode, input int pulse_at, input int rst_at);
        int idx, stalls, c, guard, p, csum;
        bit v;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                e.clr = 1; e.i = i; e.j = j; e.val = 0; e.last = 0;
                exq.push_back(e);
                csum = 0;
                for (int k = 0; k < 4; k++) begin
                    p = a_m[i*4+k] * b_m[k*4+j];
                    csum += p;
                    e.clr = 0; e.val = p; e.last = (k == 3);
                    exq.push_back(e);
                end
                sumq.push_back(csum);
            end
        end
        n_clr = 0; n_en = 0; n_last = 0; n_done = 0;
        done_at = 0; first_clr_at = 0; acc_sum = 0;

        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        job_base = cyc_cnt;
        chk("busy_at_cycle1", 64'(bus.busy), 64'd1);

        idx = 0; stalls = 0; c = 1;
        while (idx < 32 && c < 400) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? c[0] : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = v ? 8'((idx < 16) ? a_m[idx] : b_m[idx-16]) : 8'($urandom);
            chk("in_ready_load", 64'(bus.in_ready), 64'd1);
            @(posedge clock); #1;
            if (v) idx++; else stalls++;
            c++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);

        guard = 0;
        while (n_done == 0 && guard < 300) begin
            c = cyc_cnt - job_base + 1;
            if (c == pulse_at) bus.start = 1'b1;
            if (c == rst_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                chk("mid_reset_outputs", all_outs(), 64'd0);
                exq.delete();
                sumq.delete();
                acc_sum = 0;
                return;
            end
            @(posedge clock); #1;
            bus.start = 1'b0;
            guard++;
        end
        if (n_done == 0) chk("done_timeout", 64'd1, 64'd0);
        chk("done_cycle", 64'(done_at), 64'(113 + stalls));
        chk("first_clear_cycle", 64'(first_clr_at), 64'(33 + stalls));
        chk("clear_count", 64'(n_clr), 64'd16);
        chk("enable_count", 64'(n_en), 64'd64);
        chk("last_count", 64'(n_last), 64'd16);
        chk("steps_left", 64'(exq.size()), 64'd0);
        chk("sums_left", 64'(sumq.size()), 64'd0);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("ready_after_done", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("done_pulses", 64'(n_done), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        @(posedge clock); #1;
        chk("idle_after_reset", all_outs(), 64'd0);

        set_mats(0); run_job(0, 0, 0);    // identity, unstalled
        set_mats(1); run_job(0, 0, 0);    // all 255
        set_mats(0); run_job(1, 0, 0);    // toggled valid: 31 stalls
        set_mats(2); run_job(0, 70, 0);   // start pulsed mid-compute
        set_mats(2); run_job(0, 0, 60);   // reset at cycle 60
        repeat (2) @(posedge clock);
        #1;
        chk("idle_after_mid_reset", all_outs(), 64'd0);
        set_mats(2); run_job(2, 0, 0);    // fresh job, random backpressure
        set_mats(2); run_job(0, 0, 0);    // sequence audit

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_term_sequencer.md
# matrix_term_sequencer

Upstream feeder for the matrix accumulate unit. Loads two 4×4 unsigned 8-bit operand matrices A and B over a valid/ready byte stream, then computes C = A·B. For each output element (i,j) it first emits a clear pulse, then streams the four 16-bit partial products A[i][k]·B[k][j]. The accumulate unit sums these terms and the downstream collector reads the total. The block owns only sequencing and multiplication; it does not sum terms.

## Interface
- ELEM_WIDTH, 8, operand element width
- M_SIZE, 4, matrix dimension (square)
- DATA_WIDTH, 16, product width; fixed at 2·ELEM_WIDTH

- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- start  in  1  begin a load+compute job; honoured only in IDLE
- in_data  in  8  operand element
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- result  out  16  partial product term
- acc_enable  out  1  result is a valid term to add
- acc_clear  out  1  clear accumulator before a new element
- term_last  out  1  marks the 4th (final) term of an element
- row_idx  out  2  i of the current element
- col_idx  out  2  j of the current element
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse; job finished

## Operation
- States: IDLE, LOAD, COMPUTE, DONE.
- **IDLE**
  - in_ready=0.
  - start=1 moves to LOAD and zeroes load_cnt.
- **LOAD**
  - in_ready=1.
  - Each in_valid&in_ready cycle writes in_data to slot load_cnt, then increments load_cnt.
  - Slots 0–15 hold A, row-major (A[i][k] = slot 4i+k). Slots 16–31 hold B, row-major.
  - in_valid=0 stalls the load indefinitely. There is no timeout.
  - The 32nd handshake moves to COMPUTE and zeroes i, j, k and phase.
- **COMPUTE** runs 5 steps per element, in order (i,j) = (0,0),(0,1)…(3,3), row-major.
  - Clear step: acc_clear=1, acc_enable=0, result=0.
  - Term steps k=0..3: acc_enable=1, acc_clear=0, result = A[i][k]·B[k][j] (unsigned, zero-extended, no truncation possible).
  - term_last=1 only on k=3.
  - row_idx and col_idx show (i,j) on all 5 steps.
  - After (3,3) k=3, the next state is DONE.
- **DONE**
  - done=1 for exactly one cycle.
  - Next state is IDLE.
- Other rules:
  - acc_clear and acc_enable are never both 1.
  - Outside COMPUTE: acc_clear, acc_enable, term_last, result, row_idx and col_idx are all 0.
  - start is ignored in LOAD, COMPUTE and DONE.
  - start held high through DONE does not restart the job; a new job needs start=1 while in IDLE.
  - in_data is ignored when in_ready=0.
  - Operand storage is not cleared by reset or by a new job. Every job fully rewrites all 32 slots before they are read.

## Timing
- All outputs are registered.
- On reset (and in the cycle after any reset assertion, including mid-LOAD/COMPUTE): state=IDLE; every output is 0; load_cnt, i, j, k and phase are 0. No pending term or done pulse survives.
- Start: start sampled at cycle 0 → in_ready=1 and busy=1 from cycle 1.
- Load: with in_valid held high, handshakes occur on cycles 1–32.
- Compute: steps appear on cycles 33–112 (80 cycles = 16 elements × 5).
  - Element (i,j) begins with its clear step at cycle 33 + 5·(4i+j).
- End: done=1 at cycle 113; busy=0 and in_ready=0 from cycle 114.
- Start-to-done = 113 cycles plus the number of LOAD stall cycles.
- Multiply operands are read combinationally from storage and the product is registered. Term latency is one cycle from the step decode.

## Structure
- Package matrix_pkg holds:
  - ELEM_WIDTH, DATA_WIDTH, M_SIZE
  - derived IDX_WIDTH = $clog2(M_SIZE)
  - LOAD_COUNT = 2·M_SIZE²
  - typedef enum seq_state_t {IDLE, LOAD, COMPUTE, DONE}
- Sub-module matrix_operand_buffer:
  - 32×8 register file
  - one write port (addr, data, we)
  - two combinational read ports (A address 4i+k, B address 16+4k+j)
- FSM, counters and the multiplier stay in the top module.

## Test plan
- **Reset:** assert reset 2 cycles with start=1 and in_valid=1 → all outputs 0, in_ready=0, busy=0.
- **Identity:** A = identity, B = 1..16. Verify the following; an externally summed golden equals B.
  - Element (1,2): clear, then terms 0, 7, 0, 0.
  - term_last on the 4th term of each element.
  - done at cycle 113.
- **Max values:** all A and B = 255 → every term = 0xFE01, 64 terms total, with no overflow flag or wrap.
- **Backpressure:** in_valid toggled 1/0 every cycle → exactly 32 captures, in_ready=1 throughout LOAD. Compute output is identical to the unstalled run, shifted by 31 cycles.
- **Start/reset during a job:**
  - start pulsed during COMPUTE → no effect on sequence or count.
  - reset asserted at cycle 60 → next cycle IDLE, all outputs 0.
  - A fresh start then runs a full, correct job.
- **Sequence audit:** random A and B → exactly 16 acc_clear pulses, 64 acc_enable cycles and 16 term_last pulses. row_idx/col_idx are row-major, clear/enable are never both high, and per-element sums match the golden A·B.
